// File: rtl/vtff_bank.sv
// Bank of CHANNELS independent WIDTH-bit registers, each with its own
// hold / load / inverted-load / divided self-toggle mode and one-cycle tick.
module vtff_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CNT_W-1:0]          div,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       tick
);

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_LOAD     = 2'b01,
    MODE_LOAD_INV = 2'b10,
    MODE_TOGGLE   = 2'b11
  } mode_e;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [WIDTH-1:0] w_in;
    mode_e            w_mode;
    logic             w_limit;

    assign w_in    = in[WIDTH*c +: WIDTH];
    assign w_mode  = mode_e'(mode[2*c +: 2]);
    // >= rather than == so a shrunken div can never let the count run past it
    assign w_limit = (r_cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out  <= '0;
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (clr[c]) begin
        r_out  <= '0;
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (!en[c]) begin
        r_tick <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        unique case (w_mode)
          MODE_HOLD: begin
            r_cnt <= '0;
          end
          MODE_LOAD: begin
            r_out <= w_in;
            r_cnt <= '0;
          end
          MODE_LOAD_INV: begin
            r_out <= ~w_in;
            r_cnt <= '0;
          end
          MODE_TOGGLE: begin
            if (w_limit) begin
              r_out  <= ~r_out;
              r_cnt  <= '0;
              r_tick <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_cnt <= '0;
          end
        endcase
      end
    end

    assign out[WIDTH*c +: WIDTH] = r_out;
    assign tick[c]               = r_tick;
  end

endmodule

// File: tb/tb_vtff_bank.sv
// Directed bench for vtff_bank: per-cycle comparison against a behavioural
// model plus literal expectations for each scenario.
module tb_vtff_bank;
  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH-1:0]       en;
  logic [CH-1:0]       clr;
  logic [2*CH-1:0]     mode;
  logic [CNT_W-1:0]    div;
  logic [CH*WIDTH-1:0] in;
  logic [CH*WIDTH-1:0] out;
  logic [CH-1:0]       tick;

  int vectors = 0;
  int miscompares = 0;
  bit check_on = 1'b0;

  vtff_bank #(.WIDTH(WIDTH), .CHANNELS(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .div(div), .in(in), .out(out), .tick(tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: value, interval count and tick per channel as plain ints
  int m_val  [CH];
  int m_cnt  [CH];
  int m_tick [CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_val[c] = 0; m_cnt[c] = 0; m_tick[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        int md;
        int din;
        md  = int'(mode[2*c +: 2]);
        din = int'(in[WIDTH*c +: WIDTH]);
        m_tick[c] = 0;
        if (clr[c]) begin
          m_val[c] = 0; m_cnt[c] = 0;
        end else if (en[c]) begin
          if (md == 3) begin
            if (m_cnt[c] >= int'(div)) begin
              m_val[c] = 255 - m_val[c];
              m_cnt[c] = 0;
              m_tick[c] = 1;
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end else begin
            m_cnt[c] = 0;
            if (md == 1) m_val[c] = din;
            else if (md == 2) m_val[c] = 255 - din;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      for (int c = 0; c < CH; c++) begin
        vectors++;
        if (int'(out[WIDTH*c +: WIDTH]) != m_val[c] || int'(tick[c]) != m_tick[c]) begin
          miscompares++;
          $display("FAIL model ch%0d: out=%02h tick=%0b, expected out=%02h tick=%0d",
                   c, out[WIDTH*c +: WIDTH], tick[c], m_val[c][7:0], m_tick[c]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int ch_out(input int c);
    return int'(out[WIDTH*c +: WIDTH]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    mode[2*c +: 2] = m;
  endtask

  initial begin
    int tcount;
    rst = 1'b1; en = '0; clr = '0; mode = '0; div = '0; in = '0;
    #1;
    chk("reset_out", int'(out), 0);
    chk("reset_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    check_on = 1'b1;

    // Reset mid-cycle with A5 loaded on ch0
    set_mode(0, 2'b01); in[7:0] = 8'hA5; en[0] = 1'b1;
    cyc();
    chk("load_a5", ch_out(0), 'hA5);
    en[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_tick", int'(tick), 0);
    en[0] = 1'b1;
    cyc(); cyc();
    chk("rst_hold_out", int'(out), 0);
    rst = 1'b0; en[0] = 1'b0;

    // LOAD / LOAD_INV on ch1
    set_mode(1, 2'b01); in[15:8] = 8'h3C; en[1] = 1'b1;
    cyc();
    chk("load_3c", ch_out(1), 'h3C);
    set_mode(1, 2'b10);
    cyc();
    chk("load_inv_c3", ch_out(1), 'hC3);
    en[1] = 1'b0; in[15:8] = 8'h00;
    cyc(); cyc();
    chk("hold_c3", ch_out(1), 'hC3);

    // TOGGLE_DIV on ch2, div = 3
    div = 16'd3; set_mode(2, 2'b11); en[2] = 1'b1;
    tcount = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (tick[2]) tcount++;
      if (i == 4)  chk("tog_e4", ch_out(2), 'hFF);
      if (i == 8)  chk("tog_e8", ch_out(2), 'h00);
      if (i == 12) chk("tog_e12", ch_out(2), 'hFF);
      chk("tog_tick", int'(tick[2]), (i % 4 == 0) ? 1 : 0);
    end
    chk("tog_tick_count", tcount, 3);
    en[2] = 1'b0;

    // Pause and shrink on ch3
    div = 16'd5; set_mode(3, 2'b11); en[3] = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    en[3] = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("pause_out", ch_out(3), 0);
    chk("pause_tick", int'(tick[3]), 0);
    div = 16'd2; en[3] = 1'b1;
    cyc();
    chk("shrink_out", ch_out(3), 'hFF);
    chk("shrink_tick", int'(tick[3]), 1);
    en[3] = 1'b0;

    // Priority: clr beats en on ch0 while ch1 toggles alongside
    set_mode(0, 2'b11); set_mode(1, 2'b11); en[0] = 1'b1; en[1] = 1'b1;
    cyc(); cyc();
    chk("prio_pre_out0", ch_out(0), 0);
    clr[0] = 1'b1;
    cyc();
    chk("prio_out0", ch_out(0), 0);
    chk("prio_tick0", int'(tick[0]), 0);
    chk("prio_out1", ch_out(1), 'h3C);
    chk("prio_tick1", int'(tick[1]), 1);
    clr[0] = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
    cyc();

    // div = 0 on ch2: toggles every enabled edge
    div = 16'd0; en[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("div0_out", ch_out(2), (i % 2 == 1) ? 'h00 : 'hFF);
      chk("div0_tick", int'(tick[2]), 1);
    end
    en[2] = 1'b0;
    cyc();
    chk("div0_tick_off", int'(tick[2]), 0);

    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/vtff_bank.md
Name: vtff_bank

Overview:
- Parametrised multi-channel successor to the single edge-sensitive T flip-flop.
- Provides CHANNELS independent WIDTH-bit registers, each with a per-channel mode: hold, load, inverted load, or divided self-toggle.
- Used for LED blink patterns, divided enable/strobe generation and inverted-data latching, without instantiating one flop module per signal.
- Each channel has its own enable, synchronous clear, toggle-interval counter and one-cycle tick output.

Parameters:
- WIDTH, 8, bit width of each channel register.
- CHANNELS, 4, number of independent channels.
- CNT_W, 16, width of the per-channel toggle-interval counter and of div.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- en  input  CHANNELS  per-channel synchronous enable.
- clr  input  CHANNELS  per-channel synchronous clear.
- mode  input  2*CHANNELS  per-channel mode; channel c uses bits [2c+1:2c].
- div  input  CNT_W  shared toggle interval for mode TOGGLE_DIV; all channels use it.
- in  input  CHANNELS*WIDTH  per-channel load data; channel c uses bits [WIDTH*c+WIDTH-1:WIDTH*c].
- out  output  CHANNELS*WIDTH  per-channel register value; packed the same way as in.
- tick  output  CHANNELS  one-cycle pulse, high in the cycle out shows a toggled value.

Behaviour:
- Reset: on rst high, asynchronously, all out bits = 0, all counters = 0, all tick = 0. State stays there while rst is high. First update happens on the first rising clk edge after rst deasserts.
- Per-channel priority at each rising edge: clr > en. Channels are fully independent.
- clr[c] = 1: out_c <= 0, cnt_c <= 0, tick[c] <= 0, regardless of en and mode.
- en[c] = 0 (and clr[c] = 0): out_c and cnt_c hold; tick[c] <= 0.
- en[c] = 1 (and clr[c] = 0), by mode:
  - 00 HOLD: out_c holds; cnt_c <= 0; tick[c] <= 0.
  - 01 LOAD: out_c <= in_c; cnt_c <= 0; tick[c] <= 0.
  - 10 LOAD_INV: out_c <= ~in_c; cnt_c <= 0; tick[c] <= 0.
  - 11 TOGGLE_DIV:
    - If cnt_c >= div: out_c <= ~out_c (all WIDTH bits), cnt_c <= 0, tick[c] <= 1.
    - Else: cnt_c <= cnt_c + 1, out_c holds, tick[c] <= 0.
- Toggle period: in continuous enabled TOGGLE_DIV, out_c toggles once every div+1 enabled cycles. div = 0 toggles on every enabled edge.
- Counter clearing: any enabled cycle in a mode other than 11 clears cnt_c. Mode changes therefore restart the interval; no stale count carries over.
- Pausing: en low freezes cnt_c; counting resumes from the frozen value.
- Shrinking div: the >= comparison makes a channel whose cnt_c already exceeds a newly reduced div toggle on its next enabled edge. There is no wrap-around through 2^CNT_W.
- Counter range: cnt_c never exceeds max(previous div, current div). Increment is unsigned CNT_W bits and cannot overflow because the compare resets it first.
- Latency: out and tick are registered and update 1 clk after the qualifying edge inputs. No combinational path from inputs to outputs.
- tick[c] is never high for two consecutive cycles unless div = 0 with en held high.
- Reset mid-interval: all counters return to 0; the next toggle needs a full div+1 enabled cycles.

Test Plan:
- Reset: assert rst mid-cycle with out = 8'hA5 on ch0 -> out = 0 and tick = 0 immediately, before the next clk edge; the value holds through clock edges while rst is high.
- LOAD / LOAD_INV: ch1 mode 01, in = 8'h3C, en = 1 -> out_1 = 8'h3C next cycle. Switch to mode 10 -> out_1 = 8'hC3. Drop en -> out_1 holds 8'hC3.
- TOGGLE_DIV: ch2 from out = 0, div = 3, en held 1 for 12 cycles -> out_2 = 8'hFF after edge 4, 8'h00 after edge 8, 8'hFF after edge 12. tick[2] is high exactly in those three cycles.
- Pause and shrink: ch3 div = 5, en high 4 cycles (cnt = 4), en low 3 cycles -> no change. Then set div = 2 with en high -> toggle and tick on the first enabled edge.
- Priority and independence: ch0 clr = 1 and en = 1 in mode 11 with cnt at the div limit -> out_0 = 0, no tick. ch1 toggles in the same cycle unaffected.
- div = 0: ch2 mode 11, en = 1 for 4 cycles -> out alternates FF/00 every cycle; tick stays high all 4 cycles.
